pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload width in bits (control bundle of one pipeline stage).
REQ-002 SHALL have parameter BUBBLE, default {WIDTH{1'b0}}, meaning payload value held and driven when no valid entry exists (NOP/bubble encoding).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the bubble counter.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all held entries (branch/jump squash).
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port occupancy  output  2  number of held entries (0..2).
REQ-014 SHALL have port bubble_cnt  output  CNT_W  count of bubble cycles issued downstream.

Function
REQ-015 SHALL hold two storage entries: main (drives out_data) and skid, forming states EMPTY (0 entries), BUSY (main only), FULL (main and skid).
REQ-016 SHALL define input transfer as in_valid && in_ready and output transfer as out_valid && out_ready, both sampled at the rising clk edge.
REQ-017 SHALL drive in_ready = (state != FULL), out_valid = (state != EMPTY), and occupancy = 0/1/2 for EMPTY/BUSY/FULL, all decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-018 SHALL drive out_data = main register, and SHALL hold main = BUBBLE whenever the state is EMPTY.
REQ-019 SHALL transition EMPTY to BUSY on input transfer with main <= in_data, and SHALL otherwise stay in EMPTY.
REQ-020 SHALL transition BUSY to FULL on input-only transfer with skid <= in_data.
REQ-021 SHALL transition BUSY to EMPTY on output-only transfer with main <= BUBBLE.
REQ-022 SHALL stay in BUSY on simultaneous input and output transfer with main <= in_data, and SHALL stay in BUSY holding values when neither transfer occurs.
REQ-023 SHALL transition FULL to BUSY on output transfer with main <= skid and skid <= BUBBLE, and SHALL otherwise stay in FULL holding values.
REQ-024 SHALL give in_data a latency of 1 cycle to out_data when entering an EMPTY stage or a draining BUSY stage.
REQ-025 SHALL preserve order: no entry is lost, duplicated, or reordered outside flush/reset.
REQ-026 SHALL, on flush=1, force state EMPTY and main = skid = BUBBLE at the next edge, discarding any input transfer in that cycle; an output transfer in the flush cycle still counts as delivered.
REQ-027 SHALL increment bubble_cnt by 1 on each cycle with out_valid=0 and out_ready=1, saturating at 2^CNT_W-1 with no wrap-around.
REQ-028 SHALL leave bubble_cnt unaffected by flush.

Reset
REQ-029 SHALL take priority over flush and all transfers.
REQ-030 SHALL, at the clock edge while reset=1, set state EMPTY, main = skid = BUBBLE, and bubble_cnt = 0, yielding in_ready=1, out_valid=0, occupancy=0, out_data=BUBBLE.
REQ-031 SHALL, on reset asserted mid-operation, discard held entries with no partial update.

Verification
REQ-032 SHALL cover, with WIDTH=8, BUBBLE=8'h00: pass-through, driving in 8'hA1 with out_ready=1 -> next cycle out_valid=1 and out_data=8'hA1, occupancy=1.
REQ-033 SHALL cover backpressure: out_ready=0, push 8'h11 then 8'h22 -> occupancy=2 and in_ready=0; then out_ready=1 -> 8'h11 then 8'h22 are delivered in order.
REQ-034 SHALL cover simultaneous events: in BUSY holding 8'h33, with in 8'h44 and out_ready=1 in the same cycle -> 8'h33 is delivered, state stays BUSY, and out_data=8'h44.
REQ-035 SHALL cover flush: in FULL with in_valid=1, assert flush -> next cycle occupancy=0, out_data=8'h00, and neither held value nor input appears later.
REQ-036 SHALL cover the bubble counter with CNT_W=2: 5 empty cycles with out_ready=1 -> bubble_cnt sequence 1,2,3,3,3; a flush leaves it unchanged.
REQ-037 SHALL cover reset precedence: reset=1 and flush=1 while FULL -> all outputs reach reset values and bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage.
// The handshake outputs come only from registered state, which breaks the
// combinational ready/valid path between neighbouring stages. The main entry
// drives out_data. The skid entry catches the one extra word that can arrive
// while the downstream is stalled. A saturating counter records cycles in
// which the downstream was ready but no data was offered.
module pipe_stage_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  // Handshake and status outputs are decoded from registered state only.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    bubble_cnt = bubble_cnt_q;
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Next-state and storage update. Flush overrides every transition and
  // discards any input accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  // Bubble counter: the downstream was ready but nothing was offered. The
  // counter saturates at its maximum value and ignores flush.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers. Reset takes priority over flush and all transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      main_q       <= BUBBLE;
      skid_q       <= BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid (WIDTH=8, BUBBLE=0, CNT_W=2).
// A reference queue tracks the entries held in the stage. Each accepted input
// is pushed onto the queue. Each delivered output is popped and compared.
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] occupancy;
  logic [1:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl_q[$];
  int         mdl_bcnt = 0;
  int         sz;
  bit         mon_en = 1'b0;
  bit         mdl_out, mdl_in;

  pipe_stage_skid #(.WIDTH(8), .BUBBLE(8'h00), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle monitor. First it checks the DUT outputs against the model.
  // Then it advances the model using this cycle's inputs.
  always @(negedge clk) begin
    if (mon_en) begin
      sz = mdl_q.size();
      check_eq("mon_occ", occupancy, sz);
      check_eq("mon_in_ready", in_ready, (sz != 2));
      check_eq("mon_out_valid", out_valid, (sz != 0));
      check_eq("mon_out_data", out_data, (sz != 0) ? mdl_q[0] : 8'h00);
      check_eq("mon_bcnt", bubble_cnt, mdl_bcnt);
      if (out_valid && out_ready) begin
        $display("xfer out data=%02h", out_data);
      end
      if (reset) begin
        mdl_q.delete();
        mdl_bcnt = 0;
      end else begin
        mdl_out = (sz != 0) && out_ready;
        mdl_in  = in_valid && (sz < 2) && !flush;
        if (sz == 0 && out_ready && mdl_bcnt < 3) mdl_bcnt++;
        if (mdl_out) void'(mdl_q.pop_front());
        if (flush) mdl_q.delete();
        else if (mdl_in) mdl_q.push_back(in_data);
      end
    end
  end

  int exp_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    mon_en = 1'b1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_bcnt", bubble_cnt, 0);

    // Bubble counter saturation, then flush leaves it untouched.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bcnt_seq", bubble_cnt, exp_seq[i]);
    end
    out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("bcnt_flush", bubble_cnt, 3);

    // Pass-through.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA1;
    step();
    in_valid = 1'b0;
    check_eq("pt_valid", out_valid, 1);
    check_eq("pt_data", out_data, 8'hA1);
    check_eq("pt_occ", occupancy, 1);
    step();

    // Backpressure.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    check_eq("bp_occ", occupancy, 2);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_first", out_data, 8'h11);
    out_ready = 1'b1;
    step();
    check_eq("bp_second", out_data, 8'h22);
    step();
    check_eq("bp_drained", out_valid, 0);

    // Simultaneous input and output transfer in BUSY.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33;
    step();
    in_data = 8'h44; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("sim_occ", occupancy, 1);
    check_eq("sim_data", out_data, 8'h44);
    out_ready = 1'b1;
    step();

    // Flush while FULL with an input offered in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    step();
    in_data = 8'h66;
    step();
    in_data = 8'h77; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_occ", occupancy, 0);
    check_eq("fl_data", out_data, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("fl_no_data", out_valid, 0);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    flush = 1'b0;

    // Reset takes priority over flush while FULL. The counter is nonzero first.
    in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h9A;
    step();
    in_data = 8'h9B;
    step();
    check_eq("pre_rst_occ", occupancy, 2);
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_eq("rp_in_ready", in_ready, 1);
    check_eq("rp_out_valid", out_valid, 0);
    check_eq("rp_occ", occupancy, 0);
    check_eq("rp_out_data", out_data, 8'h00);
    check_eq("rp_bcnt", bubble_cnt, 0);
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
